// File: rtl/ir_queue_if.sv
// ---------------------------------------------------------------------------
// ir_queue_if
//   Bundles the fetch-side push port, the decode-side pop port with the
//   field-split head entry, and the occupancy count of ir_queue.
//
//   Handshake (both sides): a transfer happens at a posedge where valid and
//   ready are both high. ready never depends on valid on the push side
//   (in_ready is a pure function of count); on the pop side out_valid does
//   not depend on out_ready. A flush in the same cycle cancels any transfer.
//
//   Modports:
//     master : fetch/decode side (drives flush, in_*, out_ready)
//     slave  : the queue itself (drives in_ready, out_*, fields, count)
// ---------------------------------------------------------------------------
interface ir_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;

    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [6:0]      opcode;
    logic [31:0]     i_imm;
    logic [31:0]     s_imm;
    logic [31:0]     b_imm;
    logic [31:0]     u_imm;
    logic [31:0]     j_imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;

    logic [CW-1:0]   count;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc,
               funct3, funct7, opcode, i_imm, s_imm, b_imm, u_imm, j_imm,
               rs1, rs2, rd, count
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc,
               funct3, funct7, opcode, i_imm, s_imm, b_imm, u_imm, j_imm,
               rs1, rs2, rd, count
    );
endinterface

// File: rtl/ir_queue.sv
// ---------------------------------------------------------------------------
// ir_queue
//   DEPTH-entry instruction FIFO between fetch and decode. Each entry holds
//   an instruction word and its PC. The head entry is presented already
//   split into RV32I fields (funct3/funct7/opcode, I/S/B/U/J immediates,
//   rs1/rs2/rd). A flush discards every entry on a redirect.
//
//   Ports:
//     clk   : clock, all state changes on posedge
//     rst   : asynchronous reset, active low; clears pointers, count, storage
//     q     : ir_queue_if.slave (push port, pop port, head fields, count)
//
//   Parameters:
//     DEPTH : number of entries, power of two, >= 2
//     PC_W  : width of the stored PC
//
//   Build option:
//     IR_QUEUE_BYPASS_EN : when defined, an instruction offered to an empty
//     queue is shown on the head outputs in the same cycle and, if decode
//     takes it, is consumed without ever being written.
//
//   Output behaviour: when out_valid is low, out_instr, out_pc and every
//   decoded field read as zero.
// ---------------------------------------------------------------------------
module ir_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    ir_queue_if.slave    q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;

    logic            not_empty;
    logic            bypass;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [31:0]     head_instr;
    logic [PC_W-1:0] head_pc;

    assign not_empty = (cnt != '0);
    assign q.in_ready = (cnt < CW'(DEPTH));
    assign q.count    = cnt;

`ifdef IR_QUEUE_BYPASS_EN
    // Empty queue with a live fetch: the incoming word is the head this cycle.
    assign bypass = !not_empty && q.in_valid && !q.flush;
`else
    assign bypass = 1'b0;
`endif

    assign head_valid  = not_empty || bypass;
    assign q.out_valid = head_valid;

    // A bypassed word that decode takes right away never occupies a slot.
    assign push = q.in_valid && q.in_ready && !(bypass && q.out_ready);
    // Only stored entries advance the read pointer.
    assign pop  = not_empty && q.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (q.flush) begin
            // Redirect wins over any same-cycle push or pop.
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= q.in_instr;
                pc_mem[wr_ptr]    <= q.in_pc;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Head selection; zeroed when nothing is valid so decode sees a clean bus.
    always_comb begin
        head_instr = '0;
        head_pc    = '0;
        if (bypass) begin
            head_instr = q.in_instr;
            head_pc    = q.in_pc;
        end else if (not_empty) begin
            head_instr = instr_mem[rd_ptr];
            head_pc    = pc_mem[rd_ptr];
        end
        if (!head_valid) begin
            head_instr = '0;
            head_pc    = '0;
        end
    end

    // RV32I field split of the head word.
    always_comb begin
        q.out_instr = head_instr;
        q.out_pc    = head_pc;
        q.funct3    = head_instr[14:12];
        q.funct7    = head_instr[31:25];
        q.opcode    = head_instr[6:0];
        q.rs1       = head_instr[19:15];
        q.rs2       = head_instr[24:20];
        q.rd        = head_instr[11:7];
        q.i_imm     = {{20{head_instr[31]}}, head_instr[31:20]};
        q.s_imm     = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
        q.b_imm     = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                       head_instr[30:25], head_instr[11:8], 1'b0};
        q.u_imm     = {head_instr[31:12], 12'h000};
        q.j_imm     = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                       head_instr[20], head_instr[30:21], 1'b0};
    end
endmodule

// File: tb/tb_ir_queue.sv
// ---------------------------------------------------------------------------
// tb_ir_queue
//   Directed steps followed by random traffic against ir_queue. A queue of
//   {instr, pc} entries models the FIFO contents; head fields are derived
//   from the RV32I encoding rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_ir_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ir_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();
  ir_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (.clk(clk), .rst(rst), .q(bus));

  // ---------------- scoreboard state ----------------
  logic [31+PC_W:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic            cur_f;
  logic            cur_iv;
  logic            cur_or;
  logic [31:0]     cur_instr;
  logic [PC_W-1:0] cur_pc;

  task automatic chk(input string tag, input bit ok,
                     input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- reference decode ----------------
  function automatic logic [31:0] ref_imm(input logic [31:0] w, input int kind);
    logic [31:0] v;
    case (kind)
      0: v = 32'($signed(w) >>> 20);
      1: v = (32'($signed(w) >>> 25) << 5) | 32'(w[11:7]);
      2: v = (w[31] ? 32'hFFFF_F000 : 32'h0) | (32'(w[7]) << 11)
           | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      3: v = w & 32'hFFFF_F000;
      default: v = (w[31] ? 32'hFFF0_0000 : 32'h0) | (32'(w[19:12]) << 12)
           | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    endcase
    return v;
  endfunction

  // Compare every DUT output with the model for the current inputs.
  task automatic check_all();
    int n;
    bit byp;
    bit vld;
    logic [31+PC_W:0] h;
    logic [31:0] w;
    n   = exp_q.size();
    byp = BYP && (n == 0) && cur_iv && !cur_f && rst;
    vld = (n != 0) || byp;
    h   = '0;
    if (byp) h = {cur_instr, cur_pc};
    else if (n != 0) h = exp_q[0];
    w = h[31+PC_W:PC_W];
    chk("count", bus.count === CW'(n), 64'(bus.count), 64'(n));
    chk("in_ready", bus.in_ready === (n < DEPTH), 64'(bus.in_ready), 64'(n < DEPTH));
    chk("out_valid", bus.out_valid === vld, 64'(bus.out_valid), 64'(vld));
    chk("out_instr", bus.out_instr === w, 64'(bus.out_instr), 64'(w));
    chk("out_pc", bus.out_pc === h[PC_W-1:0], 64'(bus.out_pc), 64'(h[PC_W-1:0]));
    chk("funct3", bus.funct3 === w[14:12], 64'(bus.funct3), 64'(w[14:12]));
    chk("funct7", bus.funct7 === w[31:25], 64'(bus.funct7), 64'(w[31:25]));
    chk("opcode", bus.opcode === w[6:0], 64'(bus.opcode), 64'(w[6:0]));
    chk("rs1", bus.rs1 === w[19:15], 64'(bus.rs1), 64'(w[19:15]));
    chk("rs2", bus.rs2 === w[24:20], 64'(bus.rs2), 64'(w[24:20]));
    chk("rd", bus.rd === w[11:7], 64'(bus.rd), 64'(w[11:7]));
    chk("i_imm", bus.i_imm === ref_imm(w, 0), 64'(bus.i_imm), 64'(ref_imm(w, 0)));
    chk("s_imm", bus.s_imm === ref_imm(w, 1), 64'(bus.s_imm), 64'(ref_imm(w, 1)));
    chk("b_imm", bus.b_imm === ref_imm(w, 2), 64'(bus.b_imm), 64'(ref_imm(w, 2)));
    chk("u_imm", bus.u_imm === ref_imm(w, 3), 64'(bus.u_imm), 64'(ref_imm(w, 3)));
    chk("j_imm", bus.j_imm === ref_imm(w, 4), 64'(bus.j_imm), 64'(ref_imm(w, 4)));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a posedge; drives inputs, checks at the negedge.
  task automatic drive(input logic f, input logic iv, input logic [31:0] ins,
                       input logic [PC_W-1:0] p, input logic ordy);
    cur_f = f; cur_iv = iv; cur_instr = ins; cur_pc = p; cur_or = ordy;
    bus.flush     = f;
    bus.in_valid  = iv;
    bus.in_instr  = ins;
    bus.in_pc     = p;
    bus.out_ready = ordy;
    @(negedge clk);
    check_all();
  endtask

  // Advances one edge and applies the queue rules to the model.
  task automatic tick();
    int n;
    bit byp;
    bit vld;
    n   = exp_q.size();
    byp = BYP && (n == 0) && cur_iv && !cur_f;
    vld = (n != 0) || byp;
    @(posedge clk);
    if (cur_f) begin
      exp_q.delete();
    end else begin
      if (vld && cur_or && !byp) void'(exp_q.pop_front());
      if (cur_iv && (n < DEPTH) && !(byp && cur_or))
        exp_q.push_back({cur_instr, cur_pc});
    end
    #1;
  endtask

  task automatic push_n(input int k, input logic [31:0] base);
    for (int i = 0; i < k; i++) begin
      drive(1'b0, 1'b1, base + 32'(i), PC_W'(32'h1000 + 4 * i), 1'b0);
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    cur_f = 0; cur_iv = 0; cur_or = 0; cur_instr = '0; cur_pc = '0;
    bus.flush = 0; bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0;
    bus.out_ready = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Decode of addi sp,sp,-32
    drive(1'b0, 1'b1, 32'hFE01_0113, PC_W'(32'h40), 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("dec_valid", bus.out_valid === 1'b1, 64'(bus.out_valid), 64'(1));
    chk("dec_opcode", bus.opcode === 7'h13, 64'(bus.opcode), 64'(7'h13));
    chk("dec_rd", bus.rd === 5'd2, 64'(bus.rd), 64'(2));
    chk("dec_rs1", bus.rs1 === 5'd2, 64'(bus.rs1), 64'(2));
    chk("dec_i_imm", bus.i_imm === 32'hFFFF_FFE0, 64'(bus.i_imm), 64'(32'hFFFF_FFE0));
    chk("dec_pc", bus.out_pc === PC_W'(32'h40), 64'(bus.out_pc), 64'(32'h40));
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    tick();

    // Full / backpressure: 5 pushes, only 4 stored
    push_n(5, 32'h0000_0101);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("full_count", bus.count === CW'(4), 64'(bus.count), 64'(4));
    chk("full_in_ready", bus.in_ready === 1'b0, 64'(bus.in_ready), 64'(0));
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      chk("full_order", bus.out_instr === 32'h0000_0101 + 32'(i),
          64'(bus.out_instr), 64'(32'h0000_0101 + 32'(i)));
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("drained_count", bus.count === CW'(0), 64'(bus.count), 64'(0));
    tick();

    // Concurrent push/pop across pointer wrap
    push_n(2, 32'h0000_0200);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 32'h0000_0202 + 32'(i), PC_W'(32'h2000 + 4 * i), 1'b1);
      chk("wrap_count", bus.count === CW'(2), 64'(bus.count), 64'(2));
      chk("wrap_order", bus.out_instr === 32'h0000_0200 + 32'(i),
          64'(bus.out_instr), 64'(32'h0000_0200 + 32'(i)));
      tick();
    end
    repeat (2) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      tick();
    end

    // Flush with concurrent push and pop
    push_n(3, 32'h0000_0300);
    drive(1'b1, 1'b1, 32'h0000_03FF, PC_W'(32'h3000), 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("flush_count", bus.count === CW'(0), 64'(bus.count), 64'(0));
    chk("flush_valid", bus.out_valid === 1'b0, 64'(bus.out_valid), 64'(0));
    tick();

    // Asynchronous reset mid-stream
    push_n(3, 32'h8000_0400);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("pre_rst_count", bus.count === CW'(3), 64'(bus.count), 64'(3));
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_count", bus.count === CW'(0), 64'(bus.count), 64'(0));
    chk("rst_valid", bus.out_valid === 1'b0, 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", bus.in_ready === 1'b1, 64'(bus.in_ready), 64'(1));
    chk("rst_instr", bus.out_instr === 32'h0, 64'(bus.out_instr), 64'(0));
    chk("rst_j_imm", bus.j_imm === 32'h0, 64'(bus.j_imm), 64'(0));
    check_all();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Bypass on an empty queue with beq
    drive(1'b0, 1'b1, 32'h00C5_8063, PC_W'(32'h80), 1'b1);
`ifdef IR_QUEUE_BYPASS_EN
    chk("byp_valid", bus.out_valid === 1'b1, 64'(bus.out_valid), 64'(1));
    chk("byp_b_imm", bus.b_imm === 32'h0, 64'(bus.b_imm), 64'(0));
    chk("byp_rs2", bus.rs2 === 5'd12, 64'(bus.rs2), 64'(12));
`else
    chk("nobyp_valid", bus.out_valid === 1'b0, 64'(bus.out_valid), 64'(0));
`endif
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
`ifdef IR_QUEUE_BYPASS_EN
    chk("byp_count", bus.count === CW'(0), 64'(bus.count), 64'(0));
`else
    chk("nobyp_count", bus.count === CW'(1), 64'(bus.count), 64'(1));
`endif
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            $urandom, PC_W'($urandom), ($urandom_range(0, 2) != 0));
      tick();
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("final_count", bus.count === CW'(0), 64'(bus.count), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised instruction register successor: a DEPTH-entry FIFO of fetched instructions with PCs, sitting between fetch and decode.
- The head entry is presented already field-split: funct3, funct7, opcode, five immediate forms, rs1/rs2/rd.
- Valid/ready handshakes on both sides; a flush discards all entries on redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PC_W, 32, width of the PC stored alongside each instruction.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-low; clears all state while low.
- flush  input  1  discard all entries this cycle.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue can accept; = (count < DEPTH).
- in_instr  input  32  instruction word.
- in_pc  input  PC_W  PC of in_instr.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes head.
- out_instr  output  32  raw head word.
- out_pc  output  PC_W  head PC.
- funct3  output  3  head[14:12].
- funct7  output  7  head[31:25].
- opcode  output  7  rv32i_opcode'(head[6:0]).
- i_imm  output  32  sign-extended head[31:20].
- s_imm  output  32  sign-extended {head[31:25], head[11:7]}.
- b_imm  output  32  sign-extended {head[31], head[7], head[30:25], head[11:8], 0}.
- u_imm  output  32  {head[31:12], 12'h000}.
- j_imm  output  32  sign-extended {head[31], head[19:12], head[20], head[30:21], 0}.
- rs1, rs2, rd  output  5 each  head[19:15], head[24:20], head[11:7].
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Storage: circular buffer with read pointer, write pointer and count; pointers wrap modulo DEPTH.
- Reset (rst low, asynchronous):
  - pointers and count go to 0; storage is zeroed.
  - out_valid=0, in_ready=1, and all head-field outputs are 0.
- Push: occurs when in_valid && in_ready at posedge. Stores {in_instr, in_pc} at the write pointer and advances it.
- Pop: occurs when out_valid && out_ready at posedge. Advances the read pointer.
- Simultaneous push and pop:
  - count is unchanged.
  - When full, in_ready=0, so no push occurs even if a pop happens that cycle (no same-cycle full pass-through).
- out_valid = (count != 0).
- Head-field outputs:
  - When out_valid=0, out_instr, out_pc and all decoded fields are forced to 0.
  - Otherwise they are decoded combinationally from the head slot.
- Latency: an entry pushed at edge N is visible on the outputs after edge N (one cycle), unless the bypass feature is enabled.
- Flush:
  - Highest priority: at the edge, pointers and count go to 0. Any same-cycle push or pop is ignored.
  - in_ready remains combinational from count. The upstream stage must not treat a push accepted during a flush cycle as consumed.
- No overflow or underflow: a push is gated by in_ready and a pop by out_valid. in_valid while full and out_ready while empty are legal and have no effect.
- count never exceeds DEPTH; wrap from DEPTH-1 to 0 must be exercised.

Optional Feature:
- Macro IR_QUEUE_BYPASS_EN.
- Defined, when count==0 && in_valid && !flush:
  - out_valid=1 in the same cycle.
  - Head-field outputs decode in_instr/in_pc directly.
  - If out_ready is also high, the instruction is consumed without being written, and count stays 0.
  - If out_ready is low, it is written normally.
- Not defined: no bypass; an empty queue always shows out_valid=0, giving the one-cycle latency above.

Test Plan:
- Reset: drive rst low mid-stream with count=3 -> count=0, out_valid=0 and all fields 0 immediately; in_ready=1.
- Decode: push 32'hFE010113 (addi sp,sp,-32), PC 0x40 -> next cycle out_valid=1, opcode=7'h13, rd=2, rs1=2, i_imm=32'hFFFFFFE0, out_pc=0x40.
- Full/backpressure (DEPTH=4): push 5 words with out_ready=0 -> count=4, in_ready=0, 5th not stored. Then pop all -> order 1..4 preserved.
- Wrap/concurrent: keep count=2 with push and pop every cycle for 10 cycles -> count stays 2, output order matches input order across pointer wrap.
- Flush: count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, nothing delivered.
- Bypass (macro defined): empty queue, in_valid=1, out_ready=1, in_instr=32'h00C58063 (beq) -> same cycle out_valid=1, b_imm=0x0, rs2=12; count stays 0. Macro undefined -> out_valid=0 that cycle.
